// File: rtl/design_select_sequencer.sv
// Purpose: drives the design-select bus and GPIO isolation flag with a glitch-free isolate/deselect/apply/settle handover.
// Latency: a new nonzero select is busy ISO+RST+1+SETTLE cycles, select 0 ISO+RST cycles; reject and same-select answer next cycle.
// Backpressure: cmd_ready is high only in IDLE; requests presented while busy wait until the first IDLE cycle.
module design_select_sequencer #(
    parameter int NUM_DESIGNS   = 12,
    parameter int SEL_W         = 4,
    parameter int ISO_CYCLES    = 4,
    parameter int RST_CYCLES    = 16,
    parameter int SETTLE_CYCLES = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    input  logic [SEL_W-1:0] cmd_sel,
    output logic             cmd_ready,
    output logic [SEL_W-1:0] design_select,
    output logic             gpio_isolate,
    output logic             busy,
    output logic             done,
    output logic             err_invalid
);

    // One counter serves every timed phase, so it is sized for the longest one.
    localparam int MAX_A   = (ISO_CYCLES > RST_CYCLES) ? ISO_CYCLES : RST_CYCLES;
    localparam int MAX_CYC = (MAX_A > SETTLE_CYCLES) ? MAX_A : SETTLE_CYCLES;
    localparam int CNT_W   = $clog2(MAX_CYC + 1);

    localparam logic [CNT_W-1:0] ISO_LD    = CNT_W'(ISO_CYCLES);
    localparam logic [CNT_W-1:0] RST_LD    = CNT_W'(RST_CYCLES);
    localparam logic [CNT_W-1:0] SETTLE_LD = CNT_W'(SETTLE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO  = '0;
    localparam logic [SEL_W-1:0] MAX_SEL   = SEL_W'(NUM_DESIGNS);
    localparam logic [SEL_W-1:0] SEL_ZERO  = '0;

    typedef enum logic [2:0] {
        IDLE,
        ISOLATE,
        DESELECT,
        APPLY,
        SETTLE
    } state_t;

    state_t           state_q, state_nxt;
    logic [CNT_W-1:0] cnt_q, cnt_nxt;
    logic [SEL_W-1:0] target_q, target_nxt;
    logic [SEL_W-1:0] sel_nxt;
    logic             iso_nxt;
    logic             busy_nxt;
    logic             done_nxt;
    logic             err_nxt;

    // Ready is a pure decode of the state register, so it is glitch-free.
    assign cmd_ready = (state_q == IDLE);

    // State register and all registered outputs; reset lands on select 0 with isolation off.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            cnt_q         <= CNT_ZERO;
            target_q      <= SEL_ZERO;
            design_select <= SEL_ZERO;
            gpio_isolate  <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
            err_invalid   <= 1'b0;
        end else begin
            state_q       <= state_nxt;
            cnt_q         <= cnt_nxt;
            target_q      <= target_nxt;
            design_select <= sel_nxt;
            gpio_isolate  <= iso_nxt;
            busy          <= busy_nxt;
            done          <= done_nxt;
            err_invalid   <= err_nxt;
        end
    end

    // Next-state and next-output logic; every phase exits in the cycle its counter reads 1.
    always_comb begin
        state_nxt  = state_q;
        cnt_nxt    = cnt_q;
        target_nxt = target_q;
        sel_nxt    = design_select;
        iso_nxt    = gpio_isolate;
        busy_nxt   = busy;
        done_nxt   = 1'b0;
        err_nxt    = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    if (cmd_sel > MAX_SEL) begin
                        err_nxt = 1'b1;
                    end else if (cmd_sel == design_select) begin
                        done_nxt = 1'b1;
                    end else begin
                        target_nxt = cmd_sel;
                        state_nxt  = ISOLATE;
                        cnt_nxt    = ISO_LD;
                        iso_nxt    = 1'b1;
                        busy_nxt   = 1'b1;
                    end
                end
            end

            ISOLATE: begin
                if (cnt_q == CNT_ONE) begin
                    state_nxt = DESELECT;
                    cnt_nxt   = RST_LD;
                    sel_nxt   = SEL_ZERO;
                end else begin
                    cnt_nxt = cnt_q - CNT_ONE;
                end
            end

            DESELECT: begin
                if (cnt_q == CNT_ONE) begin
                    if (target_q == SEL_ZERO) begin
                        // Nothing to bring up: the deselected state is the destination.
                        state_nxt = IDLE;
                        cnt_nxt   = CNT_ZERO;
                        iso_nxt   = 1'b0;
                        busy_nxt  = 1'b0;
                        done_nxt  = 1'b1;
                    end else begin
                        state_nxt = APPLY;
                        cnt_nxt   = CNT_ONE;
                        sel_nxt   = target_q;
                    end
                end else begin
                    cnt_nxt = cnt_q - CNT_ONE;
                end
            end

            APPLY: begin
                state_nxt = SETTLE;
                cnt_nxt   = SETTLE_LD;
            end

            SETTLE: begin
                if (cnt_q == CNT_ONE) begin
                    state_nxt = IDLE;
                    cnt_nxt   = CNT_ZERO;
                    iso_nxt   = 1'b0;
                    busy_nxt  = 1'b0;
                    done_nxt  = 1'b1;
                end else begin
                    cnt_nxt = cnt_q - CNT_ONE;
                end
            end

            default: begin
                state_nxt = IDLE;
                cnt_nxt   = CNT_ZERO;
            end
        endcase
    end

endmodule

// File: doc/design_select_sequencer.md
Name: design_select_sequencer

Overview:
- Drives the 4-bit design-select bus and a GPIO isolation flag into the multi-design integration mux. It is the producer end of the design-select interface.
- It accepts select requests from the management side over a valid/ready handshake.
- It runs a glitch-free handover: isolate the pads, hold all designs deselected (so they sit in reset), apply the new select, let it settle, then release isolation.
- It sits between the management/config logic and the integration top.

Parameters:
- NUM_DESIGNS, 12, highest legal select value; legal requests are 0..NUM_DESIGNS.
- SEL_W, 4, select bus width.
- ISO_CYCLES, 4, cycles of pad isolation before deselecting (>=1).
- RST_CYCLES, 16, cycles design_select is held at 0 (>=1).
- SETTLE_CYCLES, 8, cycles after applying the new select before isolation is released (>=1).

Ports:
- clk  input  1  system clock; single clock domain.
- rst  input  1  asynchronous, active-high reset.
- cmd_valid  input  1  request valid.
- cmd_sel  input  SEL_W  requested design number.
- cmd_ready  output  1  high only in IDLE.
- design_select  output  SEL_W  registered select to the integration mux.
- gpio_isolate  output  1  registered; when 1, the top forces gpio_oeb to all-1 and gpio_out to 0.
- busy  output  1  high in any state other than IDLE.
- done  output  1  one-cycle pulse when a request completes.
- err_invalid  output  1  one-cycle pulse when a request is rejected.

Behaviour:
- Reset (async assert, sync deassert handled upstream): state=IDLE, design_select=0, gpio_isolate=0, busy=0, done=0, err_invalid=0, counter=0, target=0.
- States: IDLE, ISOLATE, DESELECT, APPLY, SETTLE. All outputs are registered.
- Accept rule: cmd_valid && cmd_ready at a rising edge. cmd_valid held while busy is ignored; the request is accepted at the first IDLE cycle.
- IDLE, accepted cmd_sel > NUM_DESIGNS: no state change, no output change; err_invalid=1 in the next cycle.
- IDLE, accepted cmd_sel == design_select: no sequence; done=1 in the next cycle.
- IDLE, any other accepted value:
  - latch target=cmd_sel; go to ISOLATE.
  - gpio_isolate=1 and busy=1 starting the next cycle.
- ISOLATE: hold for ISO_CYCLES cycles, then go to DESELECT with design_select=0.
- DESELECT: hold design_select=0 for RST_CYCLES cycles.
  - If target==0: go to IDLE with gpio_isolate=0 and done=1 on entry.
  - Otherwise: go to APPLY.
- APPLY: one cycle that loads design_select=target; go to SETTLE.
- SETTLE: hold for SETTLE_CYCLES cycles, then go to IDLE with gpio_isolate=0 and done=1 in the first IDLE cycle.
- Busy duration for a nonzero target: ISO+RST+1+SETTLE cycles (29 at defaults). For target 0: ISO+RST cycles (20).
- Invariants:
  - design_select never changes directly from one nonzero value to another; a 0 phase always comes between.
  - gpio_isolate is 1 whenever design_select changes.
- Counter: a single down-counter of width clog2(max(ISO,RST,SETTLE)+1). It is loaded on each state entry; the state exits in the cycle the counter reaches 1.
- rst mid-sequence: return immediately to reset values (select 0, isolation off). This is safe because select 0 means no design is driving.
- done and err_invalid are never high in the same cycle.

Test Plan:
- Reset release, then request sel=3 with valid held 1 cycle:
  - cmd_ready drops next cycle.
  - gpio_isolate=1 for 29 cycles.
  - design_select=0 for 20 cycles, then 3.
  - done pulses once; final design_select=3, gpio_isolate=0.
- From sel=3, request sel=7: design_select goes 3→0 (ISO+RST cycles after accept)→7 with no direct 3→7 transition; isolation covers the whole change.
- Request sel=13 and sel=15 while idle: err_invalid pulses once each; design_select and gpio_isolate stay unchanged; cmd_ready stays 1.
- From sel=5, request sel=5: done pulses the next cycle; busy never asserts. Then request sel=0: 20 busy cycles, then select=0 and isolate=0.
- Hold cmd_valid with sel=9 while busy on sel=2: the sel=9 request is accepted only on the first IDLE cycle after done; the two sequences run back to back.
- Assert rst 10 cycles into a sequence: design_select=0, gpio_isolate=0 and busy=0 immediately (asynchronously). After release, a fresh sel=1 request completes normally.
